// File: rtl/rv_mem_bram_responder_pkg.sv
// Shared rv_mem request/response types and width helpers used by the BRAM responder and its initiators.
package rv_mem_bram_responder_pkg;

    typedef enum logic {
        RV_MEM_WRITE = 1'b0,
        RV_MEM_READ  = 1'b1
    } rv_memory_op_e;

    function automatic int rv_mem_mask_width(input int dw);
        return dw / 8;
    endfunction

    function automatic int rv_mem_word_shift(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/rv_mem_bram_responder_resp_fifo.sv
// Two-entry valid/ready response FIFO; accepts a push while full only when the head is popped in the same cycle.
module rv_mem_bram_responder_resp_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && ((count != 2'd2) || pop);
    assign out_data  = slot[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= in_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/rv_mem_bram_responder.sv
// rv_mem responder backed by a byte-writable single-port RAM: 2-cycle in-order pipeline with a 2-entry response FIFO.
// Optional write acknowledgements enabled by defining RV_MEM_BRAM_WRITE_ACK_EN.
module rv_mem_bram_responder
    import rv_mem_bram_responder_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int ADDR_BYTE_SHIFTED = 1,
    parameter int DEPTH_LOG2        = 10,
    parameter int ID_WIDTH          = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_op,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [DATA_WIDTH/8-1:0] req_mask,
    input  logic [ID_WIDTH-1:0]     req_id,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_op,
    output logic [ID_WIDTH-1:0]     resp_id
);

    localparam int MASK_WIDTH = rv_mem_mask_width(DATA_WIDTH);
    localparam int WORD_SHIFT = (ADDR_BYTE_SHIFTED != 0) ? rv_mem_word_shift(DATA_WIDTH) : 0;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  op;
        logic [ID_WIDTH-1:0]   id;
    } rv_mem_resp_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  accept;
    logic                  is_read;
    logic                  s1_load;
    logic                  s1_valid;
    logic                  s1_op;
    logic [ID_WIDTH-1:0]   s1_id;
    logic                  ready_en;
    logic [1:0]            fifo_count;
    logic                  fifo_pop;
    logic [2:0]            occupancy;
    rv_mem_resp_t          push_resp;
    rv_mem_resp_t          head_resp;
    logic                  unused_addr;

    // Upper address bits beyond the RAM depth wrap; low byte-offset bits are ignored.
    assign word_idx    = req_addr[WORD_SHIFT +: DEPTH_LOG2];
    assign unused_addr = ^req_addr;
    assign is_read     = (req_op == RV_MEM_READ);

    // Occupancy counts the slot freed by a same-cycle pop so a full-rate stream never bubbles;
    // S1 always finds room in the FIFO on the following edge.
    assign fifo_pop  = resp_valid && resp_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, s1_valid} - {2'b00, fifo_pop};
    assign req_ready = ready_en && (occupancy < 3'd2);
    assign accept    = req_valid && req_ready;

`ifdef RV_MEM_BRAM_WRITE_ACK_EN
    assign s1_load = accept;
`else
    assign s1_load = accept && is_read;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= 1'b0;
            s1_id    <= '0;
        end else begin
            s1_valid <= s1_load;
            if (s1_load) begin
                s1_op <= req_op;
                s1_id <= req_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (is_read) begin
                ram_q <= mem[word_idx];
            end else begin
                for (int b = 0; b < MASK_WIDTH; b++) begin
                    if (req_mask[b]) begin
                        mem[word_idx][8*b +: 8] <= req_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        push_resp      = '0;
        push_resp.op   = s1_op;
        push_resp.id   = s1_id;
        push_resp.data = (s1_op == RV_MEM_READ) ? ram_q : '0;
    end

    rv_mem_bram_responder_resp_fifo #(
        .WIDTH($bits(rv_mem_resp_t))
    ) u_resp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s1_valid),
        .in_data  (push_resp),
        .out_valid(resp_valid),
        .out_ready(resp_ready),
        .out_data (head_resp),
        .count    (fifo_count)
    );

    assign resp_data = head_resp.data;
    assign resp_op   = head_resp.op;
    assign resp_id   = head_resp.id;

endmodule

// File: tb/tb_rv_mem_bram_responder.sv
// Self-checking bench for rv_mem_bram_responder: word-level memory model plus expected-response queue,
// checked every cycle, with literal checks on the directed scenarios.
module tb_rv_mem_bram_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_mask = '0;
    logic [3:0]  req_id = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_op;
    logic [3:0]  resp_id;

`ifdef RV_MEM_BRAM_WRITE_ACK_EN
    localparam int ACKS = 1;
`else
    localparam int ACKS = 0;
`endif

    rv_mem_bram_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_mask  (req_mask),
        .req_id    (req_id),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_op   (resp_op),
        .resp_id   (resp_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        op;
        logic [3:0]  id;
        int          vis;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        op;
        logic [3:0]  id;
        int          cyc;
    } log_t;

    logic [31:0] mmem [1024];
    exp_t        q[$];
    log_t        plog[$];
    int          cyc = 0;
    bit          seen_edge = 0;
    bit          exp_rv;
    bit          exp_rr;
    bit          pop;
    logic [9:0]  idx;

    // Model: each accepted response becomes visible two cycles after its accept cycle,
    // leaves on a handshake; at most two responses may be outstanding after this cycle's pop.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            q.delete();
            seen_edge = 0;
            chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
            chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
            chk("rst_resp_data", resp_data, 32'd0);
            chk("rst_resp_op", {31'b0, resp_op}, 32'd0);
            chk("rst_resp_id", {28'b0, resp_id}, 32'd0);
        end else begin
            exp_rv = (q.size() > 0) && (q[0].vis <= cyc);
            pop    = exp_rv && resp_ready;
            exp_rr = seen_edge && ((q.size() - (pop ? 1 : 0)) < 2);
            chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rr});
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_rv});
            if (exp_rv) begin
                chk("resp_data", resp_data, q[0].data);
                chk("resp_op", {31'b0, resp_op}, {31'b0, q[0].op});
                chk("resp_id", {28'b0, resp_id}, {28'b0, q[0].id});
            end
            if (pop) begin
                plog.push_back('{q[0].data, q[0].op, q[0].id, cyc});
                void'(q.pop_front());
            end
            if (req_valid && exp_rr) begin
                idx = req_addr[11:2];
                if (req_op) begin
                    q.push_back('{mmem[idx], 1'b1, req_id, cyc + 2});
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (req_mask[b]) mmem[idx][8*b +: 8] = req_data[8*b +: 8];
                    if (ACKS == 1) q.push_back('{32'd0, 1'b0, req_id, cyc + 2});
                end
            end
            seen_edge = 1;
        end
        cyc++;
    end

    task automatic issue(input logic op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [3:0] id, output int acc_cyc);
        int tries = 0;
        acc_cyc  = -1;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        req_mask  = mask;
        req_id    = id;
        forever begin
            #1;
            if (req_ready) begin
                acc_cyc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
            tries++;
            if (tries > 50) begin
                n_vec++;
                n_err++;
                $display("FAIL issue_timeout: req_ready stayed 0 for id %0d", id);
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int nth_op(input logic op, input int k);
        int seen = 0;
        for (int i = 0; i < plog.size(); i++) begin
            if (plog[i].op == op) begin
                if (seen == k) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    task automatic chk_read(input string name, input int k, input logic [31:0] data,
                            input logic [3:0] id);
        int i = nth_op(1'b1, k);
        if (i < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: read response %0d missing, got none expected id %0d", name, k, id);
        end else begin
            chk({name, "_data"}, plog[i].data, data);
            chk({name, "_id"}, {28'b0, plog[i].id}, {28'b0, id});
        end
    endtask

    int c0, c1, first, acc, ia;
    logic [31:0] wd;

    initial begin
        idle(3);
        rst_n = 1'b1;

        // Full write then read-after-write: 2-cycle latency.
        plog.delete();
        issue(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 4'd1, c0);
        issue(1'b1, 32'h10, 32'h0, 4'h0, 4'd2, c1);
        idle(4);
        chk_read("raw", 0, 32'hDEADBEEF, 4'd2);
        ia = nth_op(1'b1, 0);
        if (ia >= 0) chk("raw_latency", plog[ia].cyc - c1, 32'd2);

        // Byte-masked write merge, byte-offset address aliases the same word.
        plog.delete();
        issue(1'b0, 32'h20, 32'h11223344, 4'hF, 4'd0, c0);
        issue(1'b0, 32'h20, 32'h000000AA, 4'b0001, 4'd0, c0);
        issue(1'b1, 32'h20, 32'h0, 4'hF, 4'd3, c0);
        issue(1'b1, 32'h23, 32'h0, 4'h0, 4'd4, c0);
        idle(4);
        chk_read("merge", 0, 32'h112233AA, 4'd3);
        chk_read("offset", 1, 32'h112233AA, 4'd4);

        // Eight back-to-back reads at full rate.
        for (int i = 0; i < 8; i++) begin
            wd = 32'h01010101 * (i + 1);
            issue(1'b0, 32'h40 + 4 * i, wd, 4'hF, 4'd0, c0);
        end
        idle(4);
        plog.delete();
        for (int i = 0; i < 8; i++) issue(1'b1, 32'h40 + 4 * i, 32'h0, 4'h0, 4'(i), c0);
        idle(4);
        ia = nth_op(1'b1, 0);
        first = (ia >= 0) ? plog[ia].cyc : 0;
        for (int i = 0; i < 8; i++) begin
            wd = 32'h01010101 * (i + 1);
            chk_read("burst", i, wd, 4'(i));
            ia = nth_op(1'b1, i);
            if (ia >= 0) chk("burst_cycle", plog[ia].cyc, first + i);
        end

        // Backpressure: continuous requests with resp_ready low.
        plog.delete();
        resp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1;
        req_op = 1'b1;
        req_addr = 32'h10;
        req_mask = 4'h0;
        for (int i = 0; i < 10; i++) begin
            req_id = 4'(8 + acc);
            #1;
            if (req_ready) acc++;
            @(negedge clk);
        end
        chk("bp_accepted", acc, 32'd2);
        chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        idle(4);
        chk_read("bp_drain0", 0, 32'hDEADBEEF, 4'd8);
        chk_read("bp_drain1", 1, 32'hDEADBEEF, 4'd9);

        // Reset with S1 and FIFO both holding responses.
        resp_ready = 1'b0;
        issue(1'b1, 32'h20, 32'h0, 4'h0, 4'd12, c0);
        issue(1'b1, 32'h40, 32'h0, 4'h0, 4'd13, c0);
        plog.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_imm_resp_valid", {31'b0, resp_valid}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        idle(5);
        chk("rst_no_stale", plog.size(), 32'd0);
        issue(1'b1, 32'h10, 32'h0, 4'h0, 4'd5, c0);
        idle(4);
        chk_read("rst_retained", 0, 32'hDEADBEEF, 4'd5);

        // Write acknowledgement, no-op mask write, address wrap.
        plog.delete();
        issue(1'b0, 32'h80, 32'h00000055, 4'hF, 4'd10, c0);
        idle(3);
        issue(1'b0, 32'h80, 32'hFFFFFFFF, 4'h0, 4'd14, c0);
        idle(3);
        issue(1'b1, 32'h80, 32'h0, 4'h0, 4'd11, c0);
        issue(1'b1, 32'h1080, 32'h0, 4'h0, 4'd15, c0);
        idle(4);
        chk_read("ack_read", 0, 32'h00000055, 4'd11);
        chk_read("wrap_read", 1, 32'h00000055, 4'd15);
        acc = 0;
        for (int i = 0; i < plog.size(); i++) if (plog[i].op == 1'b0) acc++;
        chk("write_acks", acc, 2 * ACKS);
        ia = nth_op(1'b0, 0);
        if (ACKS == 1 && ia >= 0) begin
            chk("ack_data", plog[ia].data, 32'd0);
            chk("ack_id", {28'b0, plog[ia].id}, 32'd10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
